// File: rtl/seq_add_pkg.sv
// Shared definitions for the sequential slice adder: FSM state encoding,
// default slice geometry and the index-width helper.
package seq_add_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Slice index width: clog2(K), never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/seq_add_ctrl_if.sv
// Request/result bundle for seq_add_ctrl.
// Optional macro SUBTRACT_EN adds the sub select.
//
// Handshake: the requester raises start with a/b (and sub) valid; the
// request is taken at the first rising edge where the controller is idle
// (busy=0). While busy=1, start is ignored. The result is valid on sum and
// carry_out in the cycle where done=1 and holds until the next taken start.
interface seq_add_ctrl_if #(parameter int W = 16);
  import seq_add_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SUBTRACT_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  state_t       dbg_state;

`ifdef SUBTRACT_EN
  modport master (output start, a, b, sub,
                  input  busy, done, sum, carry_out, dbg_state);
  modport slave  (input  start, a, b, sub,
                  output busy, done, sum, carry_out, dbg_state);
`else
  modport master (output start, a, b,
                  input  busy, done, sum, carry_out, dbg_state);
  modport slave  (input  start, a, b,
                  output busy, done, sum, carry_out, dbg_state);
`endif

endinterface

// File: rtl/seq_add_ctrl_adder_slice.sv
// adder_slice: combinational N-bit ripple-carry adder with carry in/out.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    logic [N:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: W = N*K bit adder that reuses one N-bit slice over K cycles.
// Optional macro SUBTRACT_EN enables a-b via the sub select (b inverted,
// initial carry 1; carry_out=1 then means no borrow).
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  seq_add_ctrl_if.slave  bus
);

  localparam int W     = N * K;
  localparam int IDX_W = idx_width(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [N-1:0]     sl_a, sl_b, sl_s;
  logic             sl_c;
  logic             op_sub;

`ifdef SUBTRACT_EN
  assign op_sub = bus.sub;
`else
  assign op_sub = 1'b0;
`endif

  // Current slice of the latched operands feeds the shared adder.
  assign sl_a = a_q[int'(idx_q)*N +: N];
  assign sl_b = b_q[int'(idx_q)*N +: N];

  adder_slice #(.N(N)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  // Next-state and datapath updates; registers hold unless a state acts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = op_sub ? ~bus.b : bus.b;
          idx_d   = '0;
          carry_d = op_sub;
          sum_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[int'(idx_q)*N +: N] = sl_s;
        carry_d = sl_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_c;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == BUSY) || (state_q == DONE);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Bench for seq_add_ctrl (N=4, K=4). Build with +define+SUBTRACT_EN to
// exercise subtraction as well.
module tb_seq_add_ctrl;
  import seq_add_pkg::*;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  logic [W:0] exp_q[$];
  int         lat_q[$];

  seq_add_ctrl_if #(.W(W)) bus ();

  seq_add_ctrl #(.N(N), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain W-bit arithmetic, {carry, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    logic [W-1:0] d;
    if (s) begin
      d = a - b;
      return {(a >= b), d};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        logic [W:0] e;
        int         l;
        e = exp_q.pop_front();
        l = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        chk("result", {15'd0, bus.carry_out, bus.sum}, {15'd0, e});
        chk("latency", cyc, l);
      end
    end
  end

  // Driver: wait for idle, present one request, scramble operands afterwards.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_wait_timeout", 1, 0);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
`ifdef SUBTRACT_EN
    bus.sub   = s;
`endif
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    lat_q.push_back(cyc + K + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
`ifdef SUBTRACT_EN
    bus.sub   = 1'($urandom);
`endif
  endtask

  // Bounded wait until every issued request has been reported.
  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [W:0] r;
    int         d0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SUBTRACT_EN
    bus.sub   = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_sum", 32'(bus.sum), 0);
    chk("reset_carry", 32'(bus.carry_out), 0);
    rst = 1'b0;

    op(16'h1234, 16'h4321, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    wait_idle();
    chk("ripple_sum", 32'(bus.sum), 32'h0000);
    chk("ripple_carry", 32'(bus.carry_out), 1);

    // Result must hold while idle regardless of operand activity.
    r = model(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
      chk("hold_result", {15'd0, bus.carry_out, bus.sum}, {15'd0, r});
    end

    // Start while busy is ignored.
    d0 = done_cnt;
    op(16'h0F0F, 16'h0101, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hAAAA;
    bus.b     = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (K + 3) @(negedge clk);
    chk("ignored_start_sum", 32'(bus.sum), 32'h1010);
    chk("ignored_start_dones", done_cnt - d0, 1);

    // Reset during BUSY aborts without a done pulse.
    d0 = done_cnt;
    op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_sum", 32'(bus.sum), 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (K + 3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    op(16'h0800, 16'h0880, 1'b0);
    wait_idle();

`ifdef SUBTRACT_EN
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h0009, 16'h0004, 1'b1);
    wait_idle();
`endif

    // Randomised traffic, including operand edge values.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = (i % 7 == 0) ? '1 : W'($urandom);
      rb = (i % 5 == 0) ? '0 : W'($urandom);
      rs = 1'b0;
`ifdef SUBTRACT_EN
      rs = 1'($urandom_range(0, 1));
`endif
      op(ra, rb, rs);
    end
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 Parameter N, default 4: adder slice width in bits.
REQ-002 Parameter K, default 4: number of slices; operand width W = N*K.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to add a and b; sampled only in IDLE.
REQ-006 a  input  W  operand A; sampled on the accepted start.
REQ-007 b  input  W  operand B; sampled on the accepted start.
REQ-008 sub  input  1  subtract select; present only when SUBTRACT_EN is defined.
REQ-009 busy  output  1  high in BUSY and DONE.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 sum  output  W  result register.
REQ-012 carry_out  output  1  final carry out of the top slice.

Function
REQ-013 The block SHALL be an FSM with states IDLE, BUSY and DONE, reusing one N-bit slice adder over K cycles.
REQ-014 IDLE with start=1: latch a and b, set slice index 0, set the carry register to 0, and go to BUSY next cycle.
REQ-015 IDLE with start=0: remain in IDLE; sum and carry_out hold their values.
REQ-016 BUSY, each cycle:
- Add slice [idx*N +: N] of A and B with the carry register.
- Write the N-bit result into sum[idx*N +: N].
- Load the carry register with the slice carry.
- Increment idx.
REQ-017 BUSY at idx=K-1: after that slice update, carry_out SHALL take the slice carry and the FSM SHALL go to DONE.
REQ-018 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-019 Latency: start accepted at edge t SHALL give done=1 in the cycle after edge t+K+1; the next start is accepted no earlier than the cycle after done.
REQ-020 start while busy=1 SHALL be ignored; it SHALL NOT affect latched operands, state or results.
REQ-021 sum and carry_out SHALL stay stable from done until the next accepted start; on that start, sum SHALL clear to 0.
REQ-022 Arithmetic: unsigned, modulo 2^W; carry_out is bit W of a+b.
REQ-023 Operand inputs SHALL NOT be used after the start cycle; changing a or b mid-operation SHALL NOT affect the result.
REQ-024 idx width SHALL be clog2(K), minimum 1; K=1 SHALL complete in one BUSY cycle.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear idx, the carry register, the operand registers, sum, carry_out, done and busy to 0, overriding start.
REQ-026 rst asserted mid-BUSY SHALL abort the operation with no done pulse; start is accepted again the first edge after rst falls.

Configuration
REQ-027 Macro SUBTRACT_EN: when defined, port sub exists. On an accepted start with sub=1:
- Latch ~b instead of b.
- Set the initial carry to 1.
- sum SHALL equal a-b mod 2^W; carry_out=1 means no borrow.
REQ-028 Without SUBTRACT_EN: no sub port, initial carry is always 0, and the block is add-only.

Structure
REQ-029 Package seq_add_pkg SHALL hold:
- the state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
- default constants for N and K.
REQ-030 Sub-module adder_slice (N-bit ripple adder with carry-in and carry-out, combinational) SHALL be instantiated once; the FSM, operand registers and result register live in seq_add_ctrl.
REQ-031 Unused state encoding 2'b11 SHALL recover to IDLE.

Verification (N=4, K=4, W=16)
REQ-032 rst held 2 cycles -> busy=0, done=0, sum=16'h0000, carry_out=0.
REQ-033 start, a=16'h1234, b=16'h4321 -> done pulse 5 cycles after the start edge, sum=16'h5555, carry_out=0.
REQ-034 start, a=16'hFFFF, b=16'h0001 -> carry ripples through all slices; sum=16'h0000, carry_out=1.
REQ-035 start a=16'h0F0F, b=16'h0101; then start again 2 cycles later with a=16'hAAAA -> second start ignored; sum=16'h1010, exactly one done.
REQ-036 rst pulsed 2 cycles after start -> busy=0 and sum=16'h0000 next cycle; no done pulse; a new start then completes normally.
REQ-037 SUBTRACT_EN: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, carry_out=0.
REQ-038 SUBTRACT_EN: a=16'h0009, b=16'h0004, sub=1 -> sum=16'h0005, carry_out=1.
